// File: rtl/checkout_controller.sv
// Scan sequencer for item classification: capture, 1-cycle evaluate, hold display window, ack/reject/alarm.
// Latency: verdict at edge t+1 after scan; scan_ack the cycle after edge t+1+HOLD_CYCLES. Scans outside IDLE are dropped.
module checkout_controller #(
    parameter int HOLD_CYCLES = 25000000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             scan_req,
    input  logic [2:0]       upc,
    input  logic             mark,
    input  logic             clear_req,
    output logic             busy,
    output logic             scan_ack,
    output logic             reject,
    output logic             alarm,
    output logic             disp_valid,
    output logic [2:0]       disp_code,
    output logic             disp_discount,
    output logic [CNT_W-1:0] item_count,
    output logic [CNT_W-1:0] discount_count
);

    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EVAL  = 3'd1,
        SHOW  = 3'd2,
        ACK   = 3'd3,
        REJ   = 3'd4,
        ALARM = 3'd5
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      cap_upc;
    logic            cap_mark;
    logic [TW-1:0]   hold_cnt;

    logic cap_u, cap_p, cap_c;
    logic code_ok, is_discount, is_stolen, hold_done;
    logic do_clear, do_capture, do_accept;

    assign {cap_u, cap_p, cap_c} = cap_upc;
    assign code_ok     = (cap_upc != 3'b010) && (cap_upc != 3'b111);
    assign is_discount = (cap_u & cap_c) | cap_p;
    assign is_stolen   = ~(cap_mark | cap_p | (~cap_u & cap_c));
    assign hold_done   = (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nxt  = state;
        do_clear   = 1'b0;
        do_capture = 1'b0;
        do_accept  = 1'b0;
        case (state)
            IDLE: begin
                // a simultaneous clear wins and the scan is dropped
                if (clear_req) begin
                    do_clear = 1'b1;
                end else if (scan_req) begin
                    do_capture = 1'b1;
                    state_nxt  = EVAL;
                end
            end
            EVAL: begin
                if (!code_ok) begin
                    state_nxt = REJ;
                end else if (is_stolen) begin
                    state_nxt = ALARM;
                end else begin
                    do_accept = 1'b1;
                    state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (clear_req) begin
                    do_clear  = 1'b1;
                    state_nxt = IDLE;
                end else if (hold_done) begin
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            REJ:     state_nxt = IDLE;
            ALARM: begin
                if (clear_req) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Status outputs are flops loaded from the next state so they align with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            scan_ack <= 1'b0;
            reject   <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            busy     <= (state_nxt != IDLE);
            scan_ack <= (state_nxt == ACK);
            reject   <= (state_nxt == REJ);
            alarm    <= (state_nxt == ALARM);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_upc        <= '0;
            cap_mark       <= 1'b0;
            hold_cnt       <= '0;
            item_count     <= '0;
            discount_count <= '0;
            disp_valid     <= 1'b0;
            disp_code      <= '0;
            disp_discount  <= 1'b0;
        end else begin
            if (do_capture) begin
                cap_upc  <= upc;
                cap_mark <= mark;
            end
            // timer idles at zero so every SHOW entry starts a fresh window
            if (state == SHOW) hold_cnt <= hold_cnt + 1'b1;
            else               hold_cnt <= '0;
            if (do_clear) begin
                item_count     <= '0;
                discount_count <= '0;
                disp_valid     <= 1'b0;
                disp_code      <= '0;
                disp_discount  <= 1'b0;
            end else if (do_accept) begin
                if (item_count != '1) item_count <= item_count + 1'b1;
                if (is_discount && (discount_count != '1)) discount_count <= discount_count + 1'b1;
                disp_code     <= cap_upc;
                disp_discount <= is_discount;
                disp_valid    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_checkout_controller.sv
// Bench for checkout_controller: two instances (8-bit and 2-bit tallies) driven in lockstep,
// table vectors, hand-written corner sequences and a randomized scan stream against a transaction model.
module tb_checkout_controller;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scan_req = 1'b0;
    logic       clear_req = 1'b0;
    logic       mark = 1'b0;
    logic [2:0] upc = 3'b000;

    logic       busy_a, scan_ack_a, reject_a, alarm_a, disp_valid_a, disp_discount_a;
    logic [2:0] disp_code_a;
    logic [7:0] item_count_a, discount_count_a;
    logic       busy_b, scan_ack_b, reject_b, alarm_b, disp_valid_b, disp_discount_b;
    logic [2:0] disp_code_b;
    logic [1:0] item_count_b, discount_count_b;

    checkout_controller #(.HOLD_CYCLES(H), .CNT_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .scan_req(scan_req), .upc(upc), .mark(mark),
        .clear_req(clear_req), .busy(busy_a), .scan_ack(scan_ack_a), .reject(reject_a),
        .alarm(alarm_a), .disp_valid(disp_valid_a), .disp_code(disp_code_a),
        .disp_discount(disp_discount_a), .item_count(item_count_a), .discount_count(discount_count_a)
    );

    checkout_controller #(.HOLD_CYCLES(H), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .scan_req(scan_req), .upc(upc), .mark(mark),
        .clear_req(clear_req), .busy(busy_b), .scan_ack(scan_ack_b), .reject(reject_b),
        .alarm(alarm_b), .disp_valid(disp_valid_b), .disp_code(disp_code_b),
        .disp_discount(disp_discount_b), .item_count(item_count_b), .discount_count(discount_count_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // transaction-level model: unbounded tallies, saturation applied per instance width
    int         m_items, m_disc;
    bit         m_dv, m_dd, m_alarm;
    logic [2:0] m_dc;

    typedef struct {
        logic [2:0] code;
        logic       mark;
        int         exp_out;   // 0 accept, 1 reject, 2 alarm
        bit         exp_disc;
    } vec_t;

    vec_t tbl[16];

    function automatic int sat(input int n, input int w);
        int mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    function automatic int outcome(input logic [2:0] c, input logic m);
        bit u = c[2];
        bit p = c[1];
        bit cc = c[0];
        if (c == 3'b010 || c == 3'b111) return 1;
        if (!(m | p | (!u & cc))) return 2;
        return 0;
    endfunction

    function automatic bit disc_of(input logic [2:0] c);
        return (c[2] & c[0]) | c[1];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input bit exp_busy);
        chk({tag, " busy_a"}, int'(busy_a), int'(exp_busy));
        chk({tag, " busy_b"}, int'(busy_b), int'(exp_busy));
        chk({tag, " alarm_a"}, int'(alarm_a), int'(m_alarm));
        chk({tag, " alarm_b"}, int'(alarm_b), int'(m_alarm));
        chk({tag, " item_count_a"}, int'(item_count_a), sat(m_items, 8));
        chk({tag, " item_count_b"}, int'(item_count_b), sat(m_items, 2));
        chk({tag, " discount_count_a"}, int'(discount_count_a), sat(m_disc, 8));
        chk({tag, " discount_count_b"}, int'(discount_count_b), sat(m_disc, 2));
        chk({tag, " disp_valid"}, int'(disp_valid_a), int'(m_dv));
        chk({tag, " disp_code"}, int'(disp_code_a), int'(m_dc));
        chk({tag, " disp_discount"}, int'(disp_discount_a), int'(m_dd));
        chk({tag, " disp_code_b"}, int'(disp_code_b), int'(m_dc));
    endtask

    task automatic model_clear;
        m_items = 0;
        m_disc  = 0;
        m_dv    = 1'b0;
        m_dd    = 1'b0;
        m_dc    = 3'b000;
    endtask

    // Issues one scan from IDLE and follows it cycle by cycle back to IDLE.
    task automatic run_scan(input logic [2:0] code, input logic m, input int exp_out, input bit exp_disc);
        scan_req = 1'b1; upc = code; mark = m;
        @(negedge clk);
        scan_req = 1'b0; upc = 3'($urandom); mark = 1'($urandom);
        chk_all("eval", 1'b1);
        chk("eval reject", int'(reject_a), 0);
        chk("eval scan_ack", int'(scan_ack_a), 0);
        @(negedge clk);
        if (exp_out == 0) begin
            m_items++;
            if (exp_disc) m_disc++;
            m_dv = 1'b1; m_dc = code; m_dd = exp_disc;
        end else if (exp_out == 2) begin
            m_alarm = 1'b1;
        end
        chk_all("verdict", 1'b1);
        chk("verdict reject_a", int'(reject_a), int'(exp_out == 1));
        chk("verdict reject_b", int'(reject_b), int'(exp_out == 1));
        chk("verdict scan_ack", int'(scan_ack_a), 0);
        if (exp_out == 1) begin
            @(negedge clk);
            chk("reject width", int'(reject_a), 0);
            chk_all("after reject", 1'b0);
        end else if (exp_out == 2) begin
            scan_req = 1'b1; upc = 3'b011; mark = 1'b1;
            @(negedge clk);
            scan_req = 1'b0;
            repeat (3) @(negedge clk);
            chk_all("alarm sticky", 1'b1);
            clear_req = 1'b1;
            @(negedge clk);
            clear_req = 1'b0;
            m_alarm = 1'b0;
            chk_all("alarm cleared", 1'b0);
        end else begin
            for (int i = 1; i < H; i++) begin
                if (i == 1) begin
                    scan_req = 1'b1; upc = 3'b110; mark = 1'b1;
                end
                @(negedge clk);
                scan_req = 1'b0;
                chk("show scan_ack", int'(scan_ack_a), 0);
                chk("show busy", int'(busy_a), 1);
            end
            @(negedge clk);
            chk("ack a", int'(scan_ack_a), 1);
            chk("ack b", int'(scan_ack_b), 1);
            chk("ack busy", int'(busy_a), 1);
            @(negedge clk);
            chk("ack width", int'(scan_ack_a), 0);
            chk_all("after ack", 1'b0);
        end
    endtask

    initial begin
        tbl[0]  = '{3'b000, 1'b0, 2, 1'b0};
        tbl[1]  = '{3'b000, 1'b1, 0, 1'b0};
        tbl[2]  = '{3'b001, 1'b0, 0, 1'b0};
        tbl[3]  = '{3'b001, 1'b1, 0, 1'b0};
        tbl[4]  = '{3'b010, 1'b0, 1, 1'b0};
        tbl[5]  = '{3'b010, 1'b1, 1, 1'b0};
        tbl[6]  = '{3'b011, 1'b0, 0, 1'b1};
        tbl[7]  = '{3'b011, 1'b1, 0, 1'b1};
        tbl[8]  = '{3'b100, 1'b0, 2, 1'b0};
        tbl[9]  = '{3'b100, 1'b1, 0, 1'b0};
        tbl[10] = '{3'b101, 1'b0, 2, 1'b1};
        tbl[11] = '{3'b101, 1'b1, 0, 1'b1};
        tbl[12] = '{3'b110, 1'b0, 0, 1'b1};
        tbl[13] = '{3'b110, 1'b1, 0, 1'b1};
        tbl[14] = '{3'b111, 1'b0, 1, 1'b0};
        tbl[15] = '{3'b111, 1'b1, 1, 1'b0};

        model_clear();
        m_alarm = 1'b0;
        #3;
        chk_all("reset", 1'b0);
        chk("reset scan_ack", int'(scan_ack_a), 0);
        chk("reset reject", int'(reject_a), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            run_scan(tbl[i].code, tbl[i].mark, tbl[i].exp_out, tbl[i].exp_disc);

        // saturation of the 2-bit instance while the 8-bit one keeps counting
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        model_clear();
        chk_all("clear idle", 1'b0);
        repeat (5) run_scan(3'b110, 1'b0, 0, 1'b1);
        chk("sat item_b", int'(item_count_b), 3);
        chk("sat disc_b", int'(discount_count_b), 3);
        chk("sat item_a", int'(item_count_a), 5);

        // scan and clear together: clear wins, no evaluation
        scan_req = 1'b1; clear_req = 1'b1; upc = 3'b011; mark = 1'b0;
        @(negedge clk);
        scan_req = 1'b0; clear_req = 1'b0;
        model_clear();
        chk_all("scan+clear", 1'b0);

        // clear during the display window aborts without an ack
        scan_req = 1'b1; upc = 3'b011; mark = 1'b0;
        @(negedge clk);
        scan_req = 1'b0;
        @(negedge clk);
        m_items = 1; m_disc = 1; m_dv = 1'b1; m_dc = 3'b011; m_dd = 1'b1;
        chk_all("show entry", 1'b1);
        scan_req = 1'b1; upc = 3'b110;
        @(negedge clk);
        scan_req = 1'b0;
        chk_all("show ignore scan", 1'b1);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        model_clear();
        chk_all("show clear", 1'b0);
        repeat (H + 2) begin
            @(negedge clk);
            chk("aborted scan_ack", int'(scan_ack_a), 0);
            chk("aborted busy", int'(busy_a), 0);
        end

        // asynchronous reset between edges during SHOW
        scan_req = 1'b1; upc = 3'b110; mark = 1'b0;
        @(negedge clk);
        scan_req = 1'b0;
        @(negedge clk);
        chk("pre-reset item", int'(item_count_a), 1);
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        chk_all("async rst show", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // asynchronous reset between edges during ALARM
        scan_req = 1'b1; upc = 3'b100; mark = 1'b0;
        @(negedge clk);
        scan_req = 1'b0;
        @(negedge clk);
        chk("pre-reset alarm", int'(alarm_a), 1);
        #2 reset_n = 1'b0;
        #1;
        m_alarm = 1'b0;
        chk_all("async rst alarm", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        run_scan(3'b011, 1'b0, 0, 1'b1);

        // randomized stream with occasional operator clears
        repeat (150) begin
            if ($urandom_range(0, 9) == 0) begin
                clear_req = 1'b1;
                @(negedge clk);
                clear_req = 1'b0;
                model_clear();
                chk_all("rand clear", 1'b0);
            end else begin
                logic [2:0] c;
                logic       mk;
                c  = 3'($urandom);
                mk = 1'($urandom);
                run_scan(c, mk, outcome(c, mk), disc_of(c));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
